// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings the board PLL out of reset, waits for a
// debounced lock with timeout and bounded retries, then enables the
// heartbeat and re-sequences the PLL whenever lock is lost.
// Runs on the free-running reference clock so it survives PLL loss.
//
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN (adds lock_loss_cnt port).
//
// Ports:
//   clk           in   reference clock, rising edge
//   n_rst         in   synchronous active-low reset
//   start         in   level request: 1 = bring up / keep up, 0 = shut down
//   pll_locked    in   PLL lock flag, asynchronous to clk
//   pll_rst       out  active-high PLL reset
//   hb_enable     out  heartbeat enable
//   ready         out  lock stable, heartbeat running
//   fault         out  retries exhausted
//   state         out  current state encoding
//   retry_cnt     out  failed attempts in the current bring-up
//   lock_loss_cnt out  saturating lock-loss count (macro only)
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 100,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       hb_enable,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int unsigned MAX_A   = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             hb_q, hb_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0]       loss_q, loss_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, retry and loss-count logic
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
    loss_d  = loss_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PLL_RST;
          retry_d = 4'd0;
        end
      end
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_PLL_RST;
            retry_d = retry_q + 4'd1;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s_q)                 state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_PLL_RST;
          retry_d = 4'd0;
`ifdef PLL_SEQ_LOSS_CNT_EN
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
`endif
        end
      end
      S_FAULT: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shutdown request overrides every transition of an active bring-up.
    if (!start && (state_q == S_PLL_RST || state_q == S_WAIT_LOCK ||
                   state_q == S_STABLE  || state_q == S_RUN)) begin
      state_d = S_IDLE;
      retry_d = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_d  = loss_q;
`endif
    end
  end

  // Output decode from next state so outputs move with state
  always_comb begin
    pll_rst_d = 1'b0;
    hb_d      = 1'b0;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      S_IDLE, S_PLL_RST: pll_rst_d = 1'b1;
      S_RUN: begin
        hb_d    = 1'b1;
        ready_d = 1'b1;
      end
      S_FAULT: begin
        fault_d   = 1'b1;
        pll_rst_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared cycle counter: clears on each state change, saturates otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      hb_q      <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_q    <= 8'd0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync1_q   <= pll_locked;
      lock_s_q  <= sync1_q;
      pll_rst_q <= pll_rst_d;
      hb_q      <= hb_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
`ifdef PLL_SEQ_LOSS_CNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign hb_enable = hb_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_HOLD=4, TIMEOUT=16,
// STABLE=8, MAX_RETRIES=2. Inputs are driven and outputs sampled on the
// falling edge. Observed vector: {state, pll_rst, hb_enable, ready, fault, retry_cnt}.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       pll_locked;
  logic       pll_rst;
  logic       hb_enable;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (16),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .hb_enable  (hb_enable),
    .ready      (ready),
    .fault      (fault),
    .state      (state),
    .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] vec(input int st, input int rc, input logic flt);
    logic [2:0] s;
    s = 3'(st);
    return {s, (st == 1 || st == 0 || st == 5), (st == 4), (st == 4), flt, 4'(rc)};
  endfunction

  task automatic test_reset();
    logic [10:0] obs;
    n_rst = 1'b0; start = 1'b0; pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
    checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
`ifdef PLL_SEQ_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_loss_cnt: got %0d expected 0", lock_loss_cnt);
    end
`endif
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: got state %0d expected 0", state);
    end
  endtask

  // pll_locked rises 3 edges after pll_rst falls; RUN exactly 10 edges after the lock edge.
  task automatic test_clean_bringup();
    logic [10:0] obs, exp;
    int st;
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      st = (k - 1 < 4) ? 1 : (k - 1 < 9) ? 2 : (k - 1 < 17) ? 3 : 4;
      exp = vec(st, 0, 1'b0);
      obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bringup_m%0d: got %h expected %h", k - 1, obs, exp);
      end
      if (k - 1 == 6) pll_locked = 1'b1;
    end
  endtask

  // Lock drops in RUN: ready falls on the third edge, then relock to RUN.
  task automatic test_lock_loss();
    logic [10:0] obs, exp;
    int st;
    pll_locked = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      st = (k < 3) ? 4 : (k < 7) ? 1 : (k < 8) ? 2 : (k < 16) ? 3 : 4;
      exp = vec(st, 0, 1'b0);
      obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lock_loss_k%0d: got %h expected %h", k, obs, exp);
      end
`ifdef PLL_SEQ_LOSS_CNT_EN
      if (k == 3 || k == 16) begin
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
          errors++;
          $display("FAIL loss_cnt_k%0d: got %0d expected 1", k, lock_loss_cnt);
        end
      end
`endif
      if (k == 3) pll_locked = 1'b1;
    end
  endtask

  task automatic test_reset_in_run();
    logic [10:0] obs;
    n_rst = 1'b0;
    @(negedge clk);
    obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
    checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL run_reset: got %h expected %h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
`ifdef PLL_SEQ_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL run_reset_loss_cnt: got %0d expected 0", lock_loss_cnt);
    end
`endif
    n_rst = 1'b1; start = 1'b0; pll_locked = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got state %0d expected 0", state);
    end
  endtask

  task automatic test_start_drop();
    logic [10:0] obs, exp;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = vec((k - 1 < 4) ? 1 : 2, 0, 1'b0);
      obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL start_drop_m%0d: got %h expected %h", k - 1, obs, exp);
      end
    end
    start = 1'b0;
    @(negedge clk);
    obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
    checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL start_drop_idle: got %h expected %h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    end
  endtask

  // Three attempts of 4 reset + 16 wait cycles, then FAULT.
  task automatic test_retries_fault();
    logic [10:0] obs, exp;
    int m;
    start = 1'b1;
    pll_locked = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      m = k - 1;
      if (m >= 60) exp = vec(5, 2, 1'b1);
      else         exp = vec(((m % 20) < 4) ? 1 : 2, m / 20, 1'b0);
      obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL retry_m%0d: got %h expected %h", m, obs, exp);
      end
    end
    start = 1'b0;
    @(negedge clk);
    obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
    checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL fault_exit: got %h expected %h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2});
    end
  endtask

  // Lock low for 3 cycles during STABLE: back to WAIT_LOCK, then a full 8 cycles.
  task automatic test_stable_glitch();
    logic [10:0] obs, exp;
    int st, m;
    start = 1'b1;
    pll_locked = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      m = k - 1;
      st = (m < 4) ? 1 : (m == 4) ? 2 : (m < 11) ? 3 : (m < 14) ? 2 : (m < 22) ? 3 : 4;
      exp = vec(st, 0, 1'b0);
      obs = {state, pll_rst, hb_enable, ready, fault, retry_cnt};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL glitch_m%0d: got %h expected %h", m, obs, exp);
      end
      if (m == 8)  pll_locked = 1'b0;
      if (m == 11) pll_locked = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_lock_loss();
    test_reset_in_run();
    test_start_drop();
    test_retries_fault();
    test_stable_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and supervision controller for the board PLL and the heartbeat blinker it clocks. It runs on the free-running reference clock, not the PLL output, so it stays alive while the PLL is unlocked. It holds the PLL in reset for a fixed time, then waits for a debounced lock with a timeout and bounded retries. Once lock is stable it enables the heartbeat and monitors for lock loss, re-sequencing the PLL when lock drops.

## Interface
- RST_HOLD_CYCLES, 100, cycles `pll_rst` is held high per attempt (≥1)
- LOCK_TIMEOUT_CYCLES, 1_000_000, max cycles in WAIT_LOCK before an attempt fails (≥1)
- LOCK_STABLE_CYCLES, 1000, consecutive synchronized-lock cycles required before RUN (≥1)
- MAX_RETRIES, 3, failed attempts tolerated before FAULT (0–15)

Ports:
- clk  in  1  reference clock; all logic on rising edge
- n_rst  in  1  synchronous, active-low reset
- start  in  1  level request: 1 = bring up and keep up, 0 = shut down
- pll_locked  in  1  PLL lock flag; asynchronous to `clk`
- pll_rst  out  1  active-high PLL reset
- hb_enable  out  1  heartbeat enable
- ready  out  1  PLL locked and stable, heartbeat running
- fault  out  1  retries exhausted
- state  out  3  current state encoding
- retry_cnt  out  4  failed attempts in the current bring-up
- lock_loss_cnt  out  8  lock-loss events; present only with PLL_SEQ_LOSS_CNT_EN

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `lock_s` is the synchronized value and is the only lock signal used.
- One shared cycle counter; width = `$clog2` of the largest count parameter plus 1. It clears on every state change.
- States and encodings: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- IDLE: `pll_rst`=1. If `start`=1, go to PLL_RST and clear `retry_cnt`.
- PLL_RST: `pll_rst`=1. After RST_HOLD_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `lock_s`=1, go to STABLE.
  - Else, if the counter reaches LOCK_TIMEOUT_CYCLES-1:
    - if `retry_cnt` == MAX_RETRIES, go to FAULT;
    - otherwise increment `retry_cnt` and go to PLL_RST.
- STABLE: `pll_rst`=0.
  - If `lock_s`=0, return to WAIT_LOCK; the timeout restarts and `retry_cnt` is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles with `lock_s`=1, go to RUN.
- RUN: `hb_enable`=1, `ready`=1, `pll_rst`=0. If `lock_s`=0, go to PLL_RST, clear `retry_cnt`, and count one lock loss.
- FAULT: `fault`=1, `pll_rst`=1. Stay here while `start`=1; go to IDLE when `start`=0.
- Priority: `start`=0 in PLL_RST, WAIT_LOCK, STABLE or RUN forces IDLE on the next edge, overriding every other transition.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state`. No combinational path from inputs to outputs.

## Timing
- Reset (`n_rst`=0 at an edge): state=IDLE, `pll_rst`=1, `hb_enable`=0, `ready`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0, synchronizer flops=0, counter=0.
- Reset has top priority in every state, including mid-attempt and in FAULT.
- `start` rising, sampled at edge E0: state=PLL_RST after E0; `pll_rst` falls exactly RST_HOLD_CYCLES edges later.
- Lock detection latency: `pll_locked` rising before edge E is visible as `lock_s`=1 after E+1; STABLE is entered at E+2.
- STABLE to `ready`=1: exactly LOCK_STABLE_CYCLES edges after STABLE entry, provided `lock_s` holds.
- Lock loss in RUN: `hb_enable` and `ready` fall 3 edges after `pll_locked` falls (2 synchronizer edges plus 1 state edge).
- MAX_RETRIES=0: the first timeout goes straight to FAULT.
- Simultaneous timeout and `lock_s`=1 in WAIT_LOCK: lock wins, go to STABLE.

## Configuration
- PLL_SEQ_LOSS_CNT_EN defined:
  - `lock_loss_cnt` port exists.
  - It increments on each RUN→PLL_RST transition and saturates at 255.
  - It clears only on reset, never on `start`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use RST_HOLD=4, TIMEOUT=16, STABLE=8, MAX_RETRIES=2.
- Clean bring-up: `pll_locked` rises 3 cycles after `pll_rst` falls → `ready`=`hb_enable`=1 exactly 2+8 edges after the lock edge; `retry_cnt`=0.
- Lock never arrives → 3 attempts of 4 reset + 16 wait cycles, `retry_cnt` reads 0,1,2, then FAULT (state=5, `fault`=1, `pll_rst`=1); `start`=0 → IDLE.
- Lock glitch in STABLE (low 3 cycles at count 5) → return to WAIT_LOCK, then a full 8 stable cycles before RUN.
- Lock loss in RUN → `ready` falls 3 edges later, state=1, `lock_loss_cnt`=1 (macro on); port absent with macro off.
- `start` dropped mid-WAIT_LOCK, and separately `n_rst` pulsed in RUN → IDLE with all outputs at their reset values on the next edge.
